// File: rtl/seg_display_arbiter_if.sv
// Bus between the three display requesters and seg_display_arbiter.
// The master modport drives the requests; the slave modport is the arbiter side.
interface seg_display_arbiter_if;
   logic [2:0]  i_Req;
   logic [15:0] i_Data0;
   logic [15:0] i_Data1;
   logic [15:0] i_Data2;
   logic [3:0]  i_DP0;
   logic [3:0]  i_DP1;
   logic [3:0]  i_DP2;
   logic [15:0] i_Idle_Digit;
   logic [2:0]  o_Ack;
   logic [15:0] o_Digit;
   logic [3:0]  o_Seg_DP_Switch;
   logic [1:0]  o_Owner;
   logic        o_Busy;

   modport master (
      output i_Req, i_Data0, i_Data1, i_Data2, i_DP0, i_DP1, i_DP2, i_Idle_Digit,
      input  o_Ack, o_Digit, o_Seg_DP_Switch, o_Owner, o_Busy
   );

   modport slave (
      input  i_Req, i_Data0, i_Data1, i_Data2, i_DP0, i_DP1, i_DP2, i_Idle_Digit,
      output o_Ack, o_Digit, o_Seg_DP_Switch, o_Owner, o_Busy
   );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin time-sharing of the 4-digit seven-segment display among three requesters.
// Define SEG_ARB_LIVE_UPDATE_EN to let the owner's word and DP pattern track its inputs during HOLD.
//
// state | meaning
// IDLE  | no owner; idle word shown live, DPs off, arbitrating every cycle
// HOLD  | display granted to o_Owner until TICK_DIV*HOLD_TICKS cycles elapse
module seg_display_arbiter #(
   parameter int TICK_DIV   = 50000,
   parameter int HOLD_TICKS = 1000
) (
   input logic                  i_clk,
   input logic                  i_rst,
   seg_display_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      HOLD = 2'b01
   } state_t;

   localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
   localparam logic [15:0] HOLD_LAST = 16'(HOLD_TICKS - 1);

   state_t      state, stateNxt;
   logic [15:0] prescaler, prescalerNxt;
   logic [15:0] holdCnt, holdCntNxt;
   logic [1:0]  lastOwner, lastOwnerNxt;
   logic [1:0]  owner, ownerNxt;
   logic [15:0] digitReg, digitNxt;
   logic [3:0]  dpReg, dpNxt;
   logic [2:0]  ack, ackNxt;

   logic [1:0]  cand0, cand1, cand2;
   logic        grantValid;
   logic [1:0]  grantIdx;
   logic        doGrant;
   logic        tick;
   logic        expire;

   function automatic logic [1:0] nextIdx(input logic [1:0] idx);
      return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

   function automatic logic [15:0] pick16(input logic [1:0] n, input logic [15:0] a,
                                          input logic [15:0] b, input logic [15:0] c);
      case (n)
         2'd0:    return a;
         2'd1:    return b;
         default: return c;
      endcase
   endfunction

   function automatic logic [3:0] pick4(input logic [1:0] n, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c);
      case (n)
         2'd0:    return a;
         2'd1:    return b;
         default: return c;
      endcase
   endfunction

   // Search order starts just after the previous owner, so a persistent requester goes to the back.
   assign cand0 = nextIdx(lastOwner);
   assign cand1 = nextIdx(cand0);
   assign cand2 = nextIdx(cand1);

   always_comb begin
      grantValid = 1'b1;
      grantIdx   = cand0;
      if (bus.i_Req[cand0]) begin
         grantIdx = cand0;
      end else if (bus.i_Req[cand1]) begin
         grantIdx = cand1;
      end else if (bus.i_Req[cand2]) begin
         grantIdx = cand2;
      end else begin
         grantValid = 1'b0;
      end
   end

   assign tick   = (prescaler == TICK_LAST);
   assign expire = (state == HOLD) && tick && (holdCnt == HOLD_LAST);

   always_comb begin
      stateNxt     = state;
      prescalerNxt = prescaler;
      holdCntNxt   = holdCnt;
      lastOwnerNxt = lastOwner;
      ownerNxt     = owner;
      digitNxt     = digitReg;
      dpNxt        = dpReg;
      ackNxt       = 3'b000;
      doGrant      = 1'b0;

      case (state)
         IDLE: begin
            doGrant = grantValid;
         end
         HOLD: begin
            if (tick) begin
               prescalerNxt = 16'd0;
               holdCntNxt   = holdCnt + 16'd1;
            end else begin
               prescalerNxt = prescaler + 16'd1;
            end
            if (expire) begin
               if (grantValid) begin
                  doGrant = 1'b1;
               end else begin
                  stateNxt     = IDLE;
                  ownerNxt     = 2'd3;
                  dpNxt        = 4'hF;
                  prescalerNxt = 16'd0;
                  holdCntNxt   = 16'd0;
               end
            end
`ifdef SEG_ARB_LIVE_UPDATE_EN
            else begin
               digitNxt = pick16(owner, bus.i_Data0, bus.i_Data1, bus.i_Data2);
               dpNxt    = pick4(owner, bus.i_DP0, bus.i_DP1, bus.i_DP2);
            end
`endif
         end
         default: begin
            stateNxt     = IDLE;
            ownerNxt     = 2'd3;
            dpNxt        = 4'hF;
            prescalerNxt = 16'd0;
            holdCntNxt   = 16'd0;
         end
      endcase

      if (doGrant) begin
         stateNxt     = HOLD;
         prescalerNxt = 16'd0;
         holdCntNxt   = 16'd0;
         lastOwnerNxt = grantIdx;
         ownerNxt     = grantIdx;
         digitNxt     = pick16(grantIdx, bus.i_Data0, bus.i_Data1, bus.i_Data2);
         dpNxt        = pick4(grantIdx, bus.i_DP0, bus.i_DP1, bus.i_DP2);
         ackNxt       = 3'b001 << grantIdx;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= IDLE;
         prescaler <= 16'd0;
         holdCnt   <= 16'd0;
         lastOwner <= 2'd2;
         owner     <= 2'd3;
         digitReg  <= 16'd0;
         dpReg     <= 4'hF;
         ack       <= 3'b000;
      end else begin
         state     <= stateNxt;
         prescaler <= prescalerNxt;
         holdCnt   <= holdCntNxt;
         lastOwner <= lastOwnerNxt;
         owner     <= ownerNxt;
         digitReg  <= digitNxt;
         dpReg     <= dpNxt;
         ack       <= ackNxt;
      end
   end

   // Idle word bypasses the register so the driver shows it without a cycle of lag.
   assign bus.o_Digit         = (state == HOLD) ? digitReg : bus.i_Idle_Digit;
   assign bus.o_Seg_DP_Switch = dpReg;
   assign bus.o_Owner         = owner;
   assign bus.o_Ack           = ack;
   assign bus.o_Busy          = (state == HOLD);

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter with TICK_DIV=4, HOLD_TICKS=3 (12-cycle holds).
// Reference model counts whole hold cycles and picks winners with modular arithmetic.
module tb_seg_display_arbiter;
   localparam int TICK_DIV   = 4;
   localparam int HOLD_TICKS = 3;
   localparam int HOLD_LEN   = TICK_DIV * HOLD_TICKS;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seg_display_arbiter_if busIf();

   seg_display_arbiter #(
      .TICK_DIV(TICK_DIV),
      .HOLD_TICKS(HOLD_TICKS)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus(busIf)
   );

   int cmpCnt = 0;
   int errCnt = 0;

   bit          mBusy;
   int          mOwner;
   int          mLast;
   int          mLeft;
   logic [15:0] mWord;
   logic [3:0]  mDp;
   logic [2:0]  mAck;

   function automatic logic [15:0] dataOf(int n);
      case (n)
         0:       return busIf.i_Data0;
         1:       return busIf.i_Data1;
         default: return busIf.i_Data2;
      endcase
   endfunction

   function automatic logic [3:0] dpOf(int n);
      case (n)
         0:       return busIf.i_DP0;
         1:       return busIf.i_DP1;
         default: return busIf.i_DP2;
      endcase
   endfunction

   function automatic int rrPick();
      for (int k = 1; k <= 3; k++) begin
         int idx;
         idx = (mLast + k) % 3;
         if (busIf.i_Req[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic void modelReset();
      mBusy  = 1'b0;
      mOwner = 3;
      mLast  = 2;
      mLeft  = 0;
      mAck   = 3'b000;
      mWord  = 16'h0000;
      mDp    = 4'hF;
   endfunction

   function automatic void modelStep();
      int win;
      bit arb;
      mAck = 3'b000;
      arb  = !mBusy;
      if (mBusy) begin
         mLeft = mLeft - 1;
         if (mLeft == 0) arb = 1'b1;
`ifdef SEG_ARB_LIVE_UPDATE_EN
         else begin
            mWord = dataOf(mOwner);
            mDp   = dpOf(mOwner);
         end
`endif
      end
      if (arb) begin
         win = rrPick();
         if (win >= 0) begin
            mBusy  = 1'b1;
            mOwner = win;
            mLast  = win;
            mLeft  = HOLD_LEN;
            mWord  = dataOf(win);
            mDp    = dpOf(win);
            mAck   = 3'(1 << win);
         end else begin
            mBusy  = 1'b0;
            mOwner = 3;
         end
      end
   endfunction

   function automatic logic [15:0] expDigit();
      return mBusy ? mWord : busIf.i_Idle_Digit;
   endfunction

   function automatic logic [3:0] expDp();
      return mBusy ? mDp : 4'hF;
   endfunction

   task automatic step();
      @(posedge clk);
      if (rst) modelReset();
      else modelStep();
      #1;
   endtask

   task automatic applyReset();
      rst = 1'b1;
      busIf.i_Req = 3'b000;
      repeat (2) step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      busIf.i_Idle_Digit = 16'hBEEF;
      applyReset();
      step();
      cmpCnt++;
      if (busIf.o_Digit !== 16'hBEEF) begin
         errCnt++; $display("FAIL reset_digit: got %h expected %h", busIf.o_Digit, 16'hBEEF);
      end
      cmpCnt++;
      if (busIf.o_Owner !== 2'd3) begin
         errCnt++; $display("FAIL reset_owner: got %0d expected 3", busIf.o_Owner);
      end
      cmpCnt++;
      if (busIf.o_Busy !== 1'b0) begin
         errCnt++; $display("FAIL reset_busy: got %b expected 0", busIf.o_Busy);
      end
      cmpCnt++;
      if (busIf.o_Ack !== 3'b000) begin
         errCnt++; $display("FAIL reset_ack: got %b expected 000", busIf.o_Ack);
      end
      cmpCnt++;
      if (busIf.o_Seg_DP_Switch !== 4'hF) begin
         errCnt++; $display("FAIL reset_dp: got %b expected 1111", busIf.o_Seg_DP_Switch);
      end
   endtask

   task automatic test_single_grant();
      int cnt;
      int guard;
      busIf.i_Data0 = 16'h1234;
      busIf.i_DP0   = 4'b1011;
      busIf.i_Req   = 3'b001;
      step();
      busIf.i_Req = 3'b000;
      cmpCnt++;
      if (busIf.o_Ack !== 3'b001) begin
         errCnt++; $display("FAIL single_ack: got %b expected 001", busIf.o_Ack);
      end
      cmpCnt++;
      if (busIf.o_Digit !== 16'h1234) begin
         errCnt++; $display("FAIL single_digit: got %h expected 1234", busIf.o_Digit);
      end
      cmpCnt++;
      if (busIf.o_Seg_DP_Switch !== 4'b1011) begin
         errCnt++; $display("FAIL single_dp: got %b expected 1011", busIf.o_Seg_DP_Switch);
      end
      cmpCnt++;
      if (busIf.o_Owner !== 2'd0) begin
         errCnt++; $display("FAIL single_owner: got %0d expected 0", busIf.o_Owner);
      end
      cnt   = (busIf.o_Busy === 1'b1) ? 1 : 0;
      guard = 0;
      while (busIf.o_Busy === 1'b1 && guard < 40) begin
         step();
         guard++;
         if (busIf.o_Busy === 1'b1) cnt++;
         cmpCnt++;
         if (busIf.o_Ack !== mAck) begin
            errCnt++; $display("FAIL single_ack_pulse: got %b expected %b", busIf.o_Ack, mAck);
         end
      end
      cmpCnt++;
      if (cnt != HOLD_LEN) begin
         errCnt++; $display("FAIL single_hold_len: got %0d expected %0d", cnt, HOLD_LEN);
      end
      cmpCnt++;
      if (busIf.o_Digit !== 16'hBEEF || busIf.o_Owner !== 2'd3) begin
         errCnt++; $display("FAIL single_back_idle: got %h/%0d expected beef/3", busIf.o_Digit, busIf.o_Owner);
      end
   endtask

   task automatic test_back_to_back();
      int expOrder [4] = '{0, 1, 2, 0};
      int seen;
      int lastCyc;
      applyReset();
      busIf.i_Data0 = 16'(($urandom));
      busIf.i_Data1 = 16'(($urandom));
      busIf.i_Data2 = 16'(($urandom));
      busIf.i_Req   = 3'b111;
      seen    = 0;
      lastCyc = 0;
      for (int cyc = 0; cyc < 38; cyc++) begin
         step();
         cmpCnt++;
         if (busIf.o_Busy !== 1'b1) begin
            errCnt++; $display("FAIL b2b_busy: cycle %0d got %b expected 1", cyc, busIf.o_Busy);
         end
         cmpCnt++;
         if (busIf.o_Ack !== mAck || busIf.o_Digit !== expDigit()) begin
            errCnt++;
            $display("FAIL b2b_model: cycle %0d got ack %b digit %h expected ack %b digit %h",
                     cyc, busIf.o_Ack, busIf.o_Digit, mAck, expDigit());
         end
         if (busIf.o_Ack !== 3'b000 && seen < 4) begin
            cmpCnt++;
            if (busIf.o_Ack !== 3'(1 << expOrder[seen])) begin
               errCnt++; $display("FAIL b2b_order: grant %0d got %b expected owner %0d", seen, busIf.o_Ack, expOrder[seen]);
            end
            if (seen > 0) begin
               cmpCnt++;
               if (cyc - lastCyc != HOLD_LEN) begin
                  errCnt++; $display("FAIL b2b_spacing: got %0d expected %0d", cyc - lastCyc, HOLD_LEN);
               end
            end
            lastCyc = cyc;
            seen++;
         end
      end
      cmpCnt++;
      if (seen != 4) begin
         errCnt++; $display("FAIL b2b_count: got %0d grants expected 4", seen);
      end
      busIf.i_Req = 3'b000;
   endtask

   task automatic test_live_update();
      logic [15:0] want;
      applyReset();
      busIf.i_Data2 = 16'h0001;
      busIf.i_DP2   = 4'b0110;
      busIf.i_Req   = 3'b100;
      step();
      busIf.i_Req = 3'b000;
      cmpCnt++;
      if (busIf.o_Ack !== 3'b100 || busIf.o_Digit !== 16'h0001) begin
         errCnt++; $display("FAIL live_grant: got ack %b digit %h expected 100/0001", busIf.o_Ack, busIf.o_Digit);
      end
      repeat (2) step();
      busIf.i_Data2 = 16'h0002;
      step();
`ifdef SEG_ARB_LIVE_UPDATE_EN
      want = 16'h0002;
`else
      want = 16'h0001;
`endif
      cmpCnt++;
      if (busIf.o_Digit !== want) begin
         errCnt++; $display("FAIL live_digit: got %h expected %h", busIf.o_Digit, want);
      end
      step();
      cmpCnt++;
      if (busIf.o_Digit !== expDigit() || busIf.o_Digit !== want) begin
         errCnt++; $display("FAIL live_digit_hold: got %h expected %h", busIf.o_Digit, want);
      end
   endtask

   task automatic test_reset_mid_hold();
      applyReset();
      busIf.i_Data0 = 16'hA5A5;
      busIf.i_Req   = 3'b001;
      step();
      busIf.i_Req = 3'b000;
      repeat (4) step();
      rst = 1'b1;
      #1;
      modelReset();
      cmpCnt++;
      if (busIf.o_Busy !== 1'b0 || busIf.o_Owner !== 2'd3) begin
         errCnt++; $display("FAIL rst_mid_state: got busy %b owner %0d expected 0/3", busIf.o_Busy, busIf.o_Owner);
      end
      cmpCnt++;
      if (busIf.o_Ack !== 3'b000 || busIf.o_Digit !== busIf.i_Idle_Digit) begin
         errCnt++; $display("FAIL rst_mid_out: got ack %b digit %h expected 000/%h", busIf.o_Ack, busIf.o_Digit, busIf.i_Idle_Digit);
      end
      repeat (2) step();
      rst = 1'b0;
      busIf.i_Req = 3'b110;
      step();
      cmpCnt++;
      if (busIf.o_Ack !== 3'b010 || busIf.o_Owner !== 2'd1) begin
         errCnt++; $display("FAIL rst_regrant: got ack %b owner %0d expected 010/1", busIf.o_Ack, busIf.o_Owner);
      end
      busIf.i_Req = 3'b000;
   endtask

   task automatic test_random();
      applyReset();
      for (int cyc = 0; cyc < 500; cyc++) begin
         if ($urandom_range(0, 3) == 0) busIf.i_Req = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 2) == 0) begin
            busIf.i_Data0 = 16'($urandom);
            busIf.i_Data1 = 16'($urandom);
            busIf.i_Data2 = 16'($urandom);
            busIf.i_DP0   = 4'($urandom);
            busIf.i_DP1   = 4'($urandom);
            busIf.i_DP2   = 4'($urandom);
         end
         if ($urandom_range(0, 15) == 0) busIf.i_Idle_Digit = 16'($urandom);
         step();
         cmpCnt++;
         if (busIf.o_Ack !== mAck) begin
            errCnt++; $display("FAIL rand_ack: cycle %0d got %b expected %b", cyc, busIf.o_Ack, mAck);
         end
         cmpCnt++;
         if (busIf.o_Owner !== 2'(mOwner)) begin
            errCnt++; $display("FAIL rand_owner: cycle %0d got %0d expected %0d", cyc, busIf.o_Owner, mOwner);
         end
         cmpCnt++;
         if (busIf.o_Busy !== mBusy) begin
            errCnt++; $display("FAIL rand_busy: cycle %0d got %b expected %b", cyc, busIf.o_Busy, mBusy);
         end
         cmpCnt++;
         if (busIf.o_Digit !== expDigit()) begin
            errCnt++; $display("FAIL rand_digit: cycle %0d got %h expected %h", cyc, busIf.o_Digit, expDigit());
         end
         cmpCnt++;
         if (busIf.o_Seg_DP_Switch !== expDp()) begin
            errCnt++; $display("FAIL rand_dp: cycle %0d got %b expected %b", cyc, busIf.o_Seg_DP_Switch, expDp());
         end
      end
   endtask

   initial begin
      busIf.i_Req        = 3'b000;
      busIf.i_Data0      = 16'h0000;
      busIf.i_Data1      = 16'h0000;
      busIf.i_Data2      = 16'h0000;
      busIf.i_DP0        = 4'hF;
      busIf.i_DP1        = 4'hF;
      busIf.i_DP2        = 4'hF;
      busIf.i_Idle_Digit = 16'hBEEF;
      modelReset();

      test_reset();
      test_single_grant();
      test_back_to_back();
      test_live_update();
      test_reset_mid_hold();
      test_random();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
      $finish;
   end
endmodule
